// File: rtl/maquina_input_scheduler.sv
// maquina_input_scheduler
// Synchronizes and debounces four coin/button switches (P, R, N, D), turns
// each debounced press into one event, and hands events to the vending FSM
// through a valid/ready register with round-robin arbitration. A press that
// arrives while an earlier press of the same switch is still queued is lost
// and recorded in a sticky drop flag.
module maquina_input_scheduler #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_raw,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic [3:0] drop,
  input  logic       drop_clr,
  output logic       busy
);

  localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_s;
  logic [3:0]  r_s_d;
  logic [15:0] r_cnt [4];
  logic [3:0]  r_pend;
  logic [3:0]  r_drop;
  logic        r_valid;
  logic [1:0]  r_code;
  logic [1:0]  r_last;

  logic [3:0]  w_rise;
  logic [3:0]  w_clr;
  logic [3:0]  w_drop_set;
  logic        w_load;
  logic [1:0]  w_idx;
  logic        w_found;

  // Two-flop synchronizer for the asynchronous switch levels.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-switch debounce: accept a new level only after it has held for
  // DEB_CYCLES consecutive synchronized cycles.
  // NOTE: the small counter array is reset element by element; it is flop
  // storage, not a RAM, so an async reset on it is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_s_d <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s_d <= r_s;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_s[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_s[i]   <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  // A rising debounced level is a press; releases carry no event.
  assign w_rise = r_s & ~r_s_d;

  // The output register may take a new event when empty or being consumed.
  assign w_load = (|r_pend) & (~r_valid | ev_ready);

  // Round-robin pick: first pending index after the last one loaded.
  // NOTE: every output is given a default before the loop so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_idx   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && r_pend[r_last + 2'(k)]) begin
        w_idx   = r_last + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_clr      = w_load ? (4'b0001 << w_idx) : 4'b0000;
  assign w_drop_set = w_rise & r_pend & ~w_clr;

  // Pending presses and sticky drop flags; a new drop wins over drop_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      r_drop <= (r_drop & ~{4{drop_clr}}) | w_drop_set;
    end
  end

  // Event output register: load, hold while stalled, or empty on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= 2'd0;
      r_last  <= 2'd3;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_code  <= w_idx;
      r_last  <= w_idx;
    end else if (r_valid && ev_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ev_valid = r_valid;
  assign ev_code  = r_code;
  assign drop     = r_drop;
  assign busy     = r_valid | (|r_pend);

endmodule

// File: doc/maquina_input_scheduler.md
MAQUINA_INPUT_SCHEDULER -- requirements
Module: maquina_input_scheduler

Interface
REQ-001 SHALL provide parameter DEB_CYCLES, default 16, number of consecutive synchronized cycles a switch level must hold before acceptance (legal 2..65535).
REQ-002 SHALL provide port clk  input  1  single clock for all state.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port sw_raw  input  4  asynchronous switch levels: bit3=P, bit2=R, bit1=N, bit0=D.
REQ-005 SHALL provide port ev_valid  output  1  event available to the vending-machine FSM.
REQ-006 SHALL provide port ev_code  output  2  index of the event's switch bit (3=P, 2=R, 1=N, 0=D).
REQ-007 SHALL provide port ev_ready  input  1  FSM accepts the event this cycle.
REQ-008 SHALL provide port drop  output  4  sticky per-switch lost-press flags.
REQ-009 SHALL provide port drop_clr  input  1  synchronous clear of all drop bits.
REQ-010 SHALL provide port busy  output  1  ev_valid OR any pending bit.

Function
REQ-011 SHALL pass each sw_raw bit through a two-flop synchronizer, giving sync[i].
REQ-012 SHALL keep per-switch debounced state s[i] and counter cnt[i]: sync[i]==s[i] -> cnt[i]<=0; otherwise cnt[i] increments, and once cnt[i]==DEB_CYCLES-1 with sync[i] still differing, s[i]<=sync[i] and cnt[i]<=0.
REQ-013 SHALL flag rise[i] for exactly one cycle, in the cycle after s[i] changes 0->1; 1->0 changes generate no event.
REQ-014 SHALL set pending[i] in the cycle after rise[i]; each pending bit holds at most one unserved press.
REQ-015 SHALL load the output register (ev_valid<=1, ev_code<=index) when at least one pending bit is set and (ev_valid==0 OR ev_ready==1), clearing that pending bit in the same cycle.
REQ-016 SHALL select the loaded index round-robin: search order last+1, last+2, last+3, last (mod 4), where last is the most recently loaded index.
REQ-017 SHALL hold ev_valid and ev_code stable while ev_valid==1 and ev_ready==0.
REQ-018 SHALL drop ev_valid to 0 after ev_valid&ev_ready when no pending bit is set; with a pending bit set, SHALL reload in that same cycle (back-to-back, one event per cycle max).
REQ-019 SHALL ignore ev_ready while ev_valid==0.
REQ-020 SHALL, on rise[i] while pending[i]==1 and pending[i] is not loaded that cycle, leave pending[i] set and set drop[i].
REQ-021 SHALL, on rise[i] in the cycle pending[i] is loaded, keep pending[i] set (new press retained, no drop).
REQ-022 SHALL give drop set priority over drop_clr in the same cycle.
REQ-023 SHALL produce a minimum latency of DEB_CYCLES+4 clk cycles from a sw_raw rising edge to ev_valid, with the system idle.

Reset
REQ-024 SHALL, while rst_n==0, asynchronously force sync flops, s, cnt, pending, drop, ev_valid to 0, ev_code to 0, and last to 3 (so D is checked first after reset).
REQ-025 SHALL, on reset asserted mid-handshake, discard the held event and all pending presses without emitting ev_valid.
REQ-026 SHALL, after reset release with a switch already held high, require the full debounce interval and then emit one event for it.

Verification (DEB_CYCLES=4)
REQ-027 SHALL test: sw_raw=0001 held, ev_ready=1 -> ev_valid=1, ev_code=0 exactly 8 cycles after the edge, lasting 1 cycle.
REQ-028 SHALL test: sw_raw bit2 toggling with a 3-cycle period for 20 cycles, then settling to 0 -> no event, drop=0000.
REQ-029 SHALL test: bits 3,1,0 rising in the same cycle, ev_ready=1 -> codes 0,1,3 on consecutive cycles; then a new bit-0 press -> code 0.
REQ-030 SHALL test: ev_ready=0 with code 1 valid and a second N press debounced -> ev_code stays 1, drop=0000; a third N press -> drop=0010; drop_clr -> 0000.
REQ-031 SHALL test: rst_n low for 1 cycle while ev_valid=1, pending=1000 -> ev_valid=0, pending=0000 immediately; no event until a new debounced press.
REQ-032 SHALL test: ev_valid=1, ev_ready pulsed for 1 cycle with pending=0100 -> ev_code changes to 2 in the next cycle and ev_valid stays 1 throughout.
